hwpe_stream_prbs_checker: RTL

HWPE_STREAM_PRBS_CHECKER -- requirements
Module: hwpe_stream_prbs_checker

---
 rtl/hwpe_stream_prbs_checker_pkg.sv | 29 ++
 rtl/hwpe_stream_prbs_checker_if.sv | 16 +
 rtl/hwpe_stream_prbs_checker_lfsr.sv | 41 ++++
 rtl/hwpe_stream_prbs_checker.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/hwpe_stream_prbs_checker_pkg.sv
// Shared types and constants for the PRBS stream checker: FSM states, LFSR masks,
// counter widths and small arithmetic helpers.
package hwpe_stream_package;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } prbs_state_e;

    localparam int unsigned EXP_LFSR_WIDTH   = 32;
    localparam int unsigned STALL_LFSR_WIDTH = 8;
    localparam int unsigned COUNT_WIDTH      = 32;
    localparam int unsigned ERR_COUNT_WIDTH  = 16;

    localparam logic [EXP_LFSR_WIDTH-1:0]   EXP_LFSR_MASK   = 32'h8020_0003;
    localparam logic [STALL_LFSR_WIDTH-1:0] STALL_LFSR_MASK = 8'hB8;
    localparam logic [EXP_LFSR_WIDTH-1:0]   EXP_LFSR_RESET  = 32'h0000_0001;

    // An all-zero seed would lock the Galois LFSR, so it is replaced by 1.
    function automatic logic [EXP_LFSR_WIDTH-1:0] fix_seed(input logic [EXP_LFSR_WIDTH-1:0] seed);
        fix_seed = (seed == 32'd0) ? EXP_LFSR_RESET : seed;
    endfunction

    function automatic logic [ERR_COUNT_WIDTH-1:0] sat_inc16(input logic [ERR_COUNT_WIDTH-1:0] v);
        sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/hwpe_stream_prbs_checker_if.sv
// Valid/ready byte-strobed stream interface; source drives data, sink drives ready.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
    logic                  valid;
    logic                  ready;

    modport source (output data, output strb, output valid, input  ready);
    modport sink   (input  data, input  strb, input  valid, output ready);

endinterface

// File: rtl/hwpe_stream_prbs_checker_lfsr.sv
// Galois right-shift LFSR with synchronous load (priority) and single-step enable.
module hwpe_stream_lfsr #(
    parameter int unsigned     WIDTH = 32,
    parameter logic [WIDTH-1:0] MASK = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_step,
    output logic [WIDTH-1:0] o_state
);

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_next;

    // Next-state selection: load wins over a step.
    always_comb begin
        w_next = r_state;
        if (i_load) begin
            w_next = i_load_val;
        end else if (i_step) begin
            w_next = (r_state >> 1) ^ (r_state[0] ? MASK : {WIDTH{1'b0}});
        end else begin
            w_next = r_state;
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= SEED;
        end else begin
            r_state <= w_next;
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/hwpe_stream_prbs_checker.sv
// Stream sink that checks incoming beats against a PRBS sequence, counts beats and
// mismatches, and throttles ready with a pseudo-random stall pattern.
module hwpe_stream_prbs_checker
    import hwpe_stream_package::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter logic [7:0]  STALL_THRESH = 8'd0,
    parameter logic [7:0]  STALL_SEED   = 8'hA5
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       enable_i,
    input  logic                       start_i,
    input  logic [31:0]                len_i,
    input  logic [31:0]                seed_i,
    hwpe_stream_intf_stream.sink       push_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic [ERR_COUNT_WIDTH-1:0] err_count_o,
    output logic [COUNT_WIDTH-1:0]     beat_count_o,
    output logic [COUNT_WIDTH-1:0]     first_err_idx_o
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    prbs_state_e                 r_state;
    prbs_state_e                 w_state_nxt;
    logic [COUNT_WIDTH-1:0]      r_len;
    logic [COUNT_WIDTH-1:0]      r_beat_cnt;
    logic [COUNT_WIDTH-1:0]      r_first_err;
    logic [ERR_COUNT_WIDTH-1:0]  r_err_cnt;
    logic                        r_err;

    logic                        w_start;
    logic                        w_ready;
    logic                        w_stall;
    logic                        w_hs;
    logic                        w_mismatch;
    logic [COUNT_WIDTH-1:0]      w_beat_inc;
    logic [EXP_LFSR_WIDTH-1:0]   w_exp_word;
    logic [EXP_LFSR_WIDTH-1:0]   w_exp_load_val;
    logic [DATA_WIDTH-1:0]       w_exp_data;
    logic [STALL_LFSR_WIDTH-1:0] w_stall_state;
    logic [STRB_WIDTH-1:0]       w_lane_diff;

    assign w_start        = (r_state == ST_IDLE) & start_i;
    assign w_stall        = (w_stall_state < STALL_THRESH);
    // Ready is built only from registered state, enable and the stall LFSR, never from valid.
    assign w_ready        = (r_state == ST_RUN) & enable_i & ~w_stall;
    assign w_hs           = push_i.valid & w_ready;
    assign w_beat_inc     = r_beat_cnt + 32'd1;
    assign w_exp_data     = DATA_WIDTH'(w_exp_word);
    assign w_exp_load_val = clear_i ? EXP_LFSR_RESET : fix_seed(seed_i);
    assign w_mismatch     = w_hs & (|w_lane_diff);

    // Per-lane compare; lanes with strobe low never flag.
    always_comb begin
        w_lane_diff = {STRB_WIDTH{1'b0}};
        for (int b = 0; b < int'(STRB_WIDTH); b++) begin
            w_lane_diff[b] = push_i.strb[b] & (push_i.data[8*b +: 8] != w_exp_data[8*b +: 8]);
        end
    end

    hwpe_stream_lfsr #(
        .WIDTH (EXP_LFSR_WIDTH),
        .MASK  (EXP_LFSR_MASK),
        .SEED  (EXP_LFSR_RESET)
    ) u_exp_lfsr (
        .i_clk      (clk_i),
        .i_rst_n    (rst_ni),
        .i_load     (clear_i | w_start),
        .i_load_val (w_exp_load_val),
        .i_step     (w_hs),
        .o_state    (w_exp_word)
    );

    hwpe_stream_lfsr #(
        .WIDTH (STALL_LFSR_WIDTH),
        .MASK  (STALL_LFSR_MASK),
        .SEED  (STALL_SEED)
    ) u_stall_lfsr (
        .i_clk      (clk_i),
        .i_rst_n    (rst_ni),
        .i_load     (clear_i),
        .i_load_val (STALL_SEED),
        .i_step     (1'b1),
        .o_state    (w_stall_state)
    );

    // FSM next-state; clear overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt = (len_i == 32'd0) ? ST_DONE : ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_hs && (w_beat_inc == r_len)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (clear_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            w_state_nxt = w_state_nxt;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Transfer length, beat and error bookkeeping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_len       <= 32'd0;
            r_beat_cnt  <= 32'd0;
            r_first_err <= 32'd0;
            r_err_cnt   <= 16'd0;
            r_err       <= 1'b0;
        end else if (clear_i) begin
            r_len       <= 32'd0;
            r_beat_cnt  <= 32'd0;
            r_first_err <= 32'd0;
            r_err_cnt   <= 16'd0;
            r_err       <= 1'b0;
        end else if (w_start) begin
            r_len       <= len_i;
            r_beat_cnt  <= 32'd0;
            r_first_err <= 32'd0;
            r_err_cnt   <= 16'd0;
            r_err       <= 1'b0;
        end else if (w_hs) begin
            r_beat_cnt <= w_beat_inc;
            if (w_mismatch) begin
                r_err     <= 1'b1;
                r_err_cnt <= sat_inc16(r_err_cnt);
                if (!r_err) begin
                    r_first_err <= r_beat_cnt;
                end
            end
        end
    end

    assign push_i.ready    = w_ready;
    assign busy_o          = (r_state == ST_RUN);
    assign done_o          = (r_state == ST_DONE);
    assign err_o           = r_err;
    assign err_count_o     = r_err_cnt;
    assign beat_count_o    = r_beat_cnt;
    assign first_err_idx_o = r_first_err;

endmodule
